alu_req_arbiter: RTL and testbench

//  Shares one combinational 8-bit ALU (op codes 000 ADD,001 SUB,010 AND,011 OR,
//  100 XOR,101 NOT(A),110 PASSB,111 INC(A)) between two requesters. It arbitrates

---
 rtl/alu_req_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_req_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each op is latched into registered ALU operands, executed for one cycle, then returned on a valid/ready port.
module alu_req_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_id;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OPW-1:0]   r_alu_op;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_hs0;
  logic w_hs1;

  // On a tie the requester that did not win last time is granted.
  assign w_idle   = (r_state == ST_IDLE);
  assign w_grant0 = req0_valid & (~req1_valid | r_last_grant);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_hs0    = w_idle & w_grant0;
  assign w_hs1    = w_idle & w_grant1;

  assign req0_ready = w_hs0;
  assign req1_ready = w_hs1;

  // Arbitration, operand capture, result capture and response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs0) begin
            r_alu_a      <= req0_a;
            r_alu_b      <= req0_b;
            r_alu_op     <= req0_op;
            r_id         <= 1'b0;
            r_last_grant <= 1'b0;
            r_state      <= ST_EXEC;
          end else if (w_hs1) begin
            r_alu_a      <= req1_a;
            r_alu_b      <= req1_b;
            r_alu_op     <= req1_op;
            r_id         <= 1'b1;
            r_last_grant <= 1'b1;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_result <= alu_result;
          r_rsp_zero   <= (alu_result == '0);
          r_rsp_id     <= r_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign busy       = ~w_idle;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a behavioural ALU drives alu_result, and a transaction-level
// model predicts grants, responses and handshake timing from the request stream.
module tb_alu_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
  logic [7:0] rsp_result;

  int n_total = 0;
  int n_bad   = 0;

  alu_req_arbiter #(.WIDTH(8), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return 8'(a + b);
      3'd1:    return 8'(a - b);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return b;
      default: return 8'(a + 8'd1);
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_a, alu_b, alu_op);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: 0 = waiting for a request, 1 = op executing, 2 = response pending.
  int         m_phase;
  logic       m_last;
  logic       m_id;
  logic [7:0] m_a, m_b, m_res;
  logic [2:0] m_op;
  logic       last_g0, last_g1;
  bit         rsp_log[$];
  int         n_g0, n_g1;

  task automatic model_reset();
    m_phase = 0; m_last = 1'b1; m_id = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_op = 3'd0; m_res = 8'h00;
  endtask

  // One clock: called at a negedge with inputs already applied, returns at the next negedge.
  task automatic cycle();
    logic g0, g1;
    #1;
    g0 = (m_phase == 0) && req0_valid && (!req1_valid || m_last);
    g1 = (m_phase == 0) && req1_valid && (!req0_valid || !m_last);
    check("ready0", 32'(req0_ready), 32'(g0));
    check("ready1", 32'(req1_ready), 32'(g1));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
    if (m_phase == 2) begin
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_result", 32'(rsp_result), 32'(m_res));
      check("rsp_zero", 32'(rsp_zero), 32'(m_res == 8'h00));
    end
    check("alu_a", 32'(alu_a), 32'(m_a));
    check("alu_b", 32'(alu_b), 32'(m_b));
    check("alu_op", 32'(alu_op), 32'(m_op));
    @(posedge clk);
    last_g0 = g0; last_g1 = g1;
    if (g0) begin
      m_a = req0_a; m_b = req0_b; m_op = req0_op; m_id = 1'b0; m_last = 1'b0;
      m_res = alu_f(req0_a, req0_b, req0_op); m_phase = 1; n_g0++;
    end else if (g1) begin
      m_a = req1_a; m_b = req1_b; m_op = req1_op; m_id = 1'b1; m_last = 1'b1;
      m_res = alu_f(req1_a, req1_b, req1_op); m_phase = 1; n_g1++;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2 && rsp_ready) begin
      rsp_log.push_back(m_id);
      m_phase = 0;
    end
    @(negedge clk);
  endtask

  task automatic issue(input int n, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bit acc = 1'b0;
    if (n == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    else        begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    for (int k = 0; k < 20 && !acc; k++) begin
      cycle();
      acc = (n == 0) ? last_g0 : last_g1;
    end
    check("issue_accept", 32'(acc), 32'd1);
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && m_phase != 0; k++) cycle();
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  // Accept, then one edge later the response must already carry the known result.
  task automatic issue_expect(input string tag, input int n, input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] op, input logic [7:0] exp_res, input logic exp_zero);
    issue(n, a, b, op);
    check({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    cycle();
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_res"}, 32'(rsp_result), 32'(exp_res));
    check({tag, "_zero"}, 32'(rsp_zero), 32'(exp_zero));
    check({tag, "_id"}, 32'(rsp_id), 32'(n));
    drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    check({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
    check({tag, "_alu"}, {13'd0, alu_op, alu_b, alu_a}, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int         s;
    logic [7:0] cap_res;
    logic       cap_id;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    n_g0 = 0; n_g1 = 0; last_g0 = 1'b0; last_g1 = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while an op is executing.
    issue(0, 8'h12, 8'h34, 3'd0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s = rsp_log.size();
    for (int k = 0; k < 4; k++) cycle();
    check("rst_no_rsp", 32'(rsp_log.size()), 32'(s));
    issue_expect("after_rst", 0, 8'h20, 8'h03, 3'd1, 8'h1D, 1'b0);
    check("rst_one_rsp", 32'(rsp_log.size()), 32'(s + 1));

    issue_expect("single", 0, 8'h0F, 8'h01, 3'd0, 8'h10, 1'b0);
    issue_expect("zero", 1, 8'h55, 8'h55, 3'd1, 8'h00, 1'b1);

    // Round-robin with both requesters continuously valid.
    s = rsp_log.size(); n_g0 = 0; n_g1 = 0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 3'($urandom);
    req1_valid = 1'b1; req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 3'($urandom);
    for (int k = 0; k < 40 && (n_g0 + n_g1) < 4; k++) begin
      cycle();
      if (last_g0) begin req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 3'($urandom); end
      if (last_g1) begin req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 3'($urandom); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();
    check("rr_count", 32'(rsp_log.size() - s), 32'd4);
    for (int k = 0; k < 4; k++) if (s + k < rsp_log.size()) check("rr_id", 32'(rsp_log[s + k]), 32'(k % 2));
    check("rr_g0", 32'(n_g0), 32'd2);
    check("rr_g1", 32'(n_g1), 32'd2);

    // Backpressure: response held for five cycles while both requesters wait.
    rsp_ready = 1'b0;
    issue(0, 8'hC3, 8'h0F, 3'd2);
    cycle();
    cap_res = rsp_result; cap_id = rsp_id;
    check("bp_valid", 32'(rsp_valid), 32'd1);
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 3'd3;
    req1_valid = 1'b1; req1_a = 8'h04; req1_b = 8'h08; req1_op = 3'd4;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_hold_res", 32'(rsp_result), 32'(cap_res));
      check("bp_hold_id", 32'(rsp_id), 32'(cap_id));
    end
    rsp_ready = 1'b1;
    cycle();
    cycle();
    check("bp_next_grant1", 32'(last_g1), 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    issue_expect("inc_wrap", 0, 8'hFF, 8'h00, 3'd7, 8'h00, 1'b1);
    issue_expect("not_a", 1, 8'hA5, 8'h00, 3'd5, 8'h5A, 1'b0);
    issue_expect("pass_b", 0, 8'h00, 8'h3C, 3'd6, 8'h3C, 1'b0);

    // Random traffic: requesters hold operands until accepted and may withdraw.
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid || last_g0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 3'($urandom);
      end else if ($urandom_range(0, 7) == 0) req0_valid = 1'b0;
      if (!req1_valid || last_g1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 3'($urandom);
      end else if ($urandom_range(0, 7) == 0) req1_valid = 1'b0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
